// File: rtl/x1_ioctl_upload_pkg.sv
// Shared definitions for the X1 ioctl upload path: region encoding, region
// sizes and the upload FSM state type.
package x1_pkg;

  typedef enum logic [1:0] {
    REG_IPL  = 2'd0,
    REG_RAM  = 2'd1,
    REG_GRAM = 2'd2,
    REG_VRAM = 2'd3
  } region_t;

  localparam logic [16:0] SZ_IPL  = 17'd8192;
  localparam logic [16:0] SZ_RAM  = 17'd65536;
  localparam logic [16:0] SZ_GRAM = 17'd65536;
  localparam logic [16:0] SZ_VRAM = 17'd4096;

  // Pointer ceiling: the largest region is 64KB, so the pointer never needs
  // to move past one-beyond-the-end of it.
  localparam logic [16:0] PTR_MAX = 17'h10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAITQ = 2'd2,
    ST_VALID = 2'd3
  } state_t;

  // Byte count of the region selected by an HPS index; unknown indices map
  // to an empty region so every byte reads as fill.
  function automatic logic [16:0] region_size(input logic [7:0] idx);
    logic [16:0] sz;
    sz = 17'd0;
    if (idx[7:2] == 6'd0) begin
      case (region_t'(idx[1:0]))
        REG_IPL:  sz = SZ_IPL;
        REG_RAM:  sz = SZ_RAM;
        REG_GRAM: sz = SZ_GRAM;
        REG_VRAM: sz = SZ_VRAM;
        default:  sz = 17'd0;
      endcase
    end
    return sz;
  endfunction

endpackage

// File: rtl/x1_ioctl_upload_lat.sv
// Read-latency tracker: a RD_LATENCY-deep shift register of the read strobe.
// Its last stage marks the cycle in which port-B data is valid.
module x1_upload_lat #(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic srst,
  input  logic flush,
  input  logic start,
  output logic hit
);

  logic [RD_LATENCY-1:0] stage_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the read strobe; flush drops stale reads of an
        // aborted session so they cannot be captured by the next one.
        always_ff @(posedge clk) begin
          if (srst || flush) stage_reg[gi] <= 1'b0;
          else               stage_reg[gi] <= start;
        end
      end else begin : g_rest
        // Later stages delay the strobe by one cycle each.
        always_ff @(posedge clk) begin
          if (srst || flush) stage_reg[gi] <= 1'b0;
          else               stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign hit = stage_reg[RD_LATENCY-1];

endmodule

// File: rtl/x1_ioctl_upload.sv
// X1 memory-region upload to the HPS over the ioctl upload handshake.
// Optional macro X1_UPLOAD_CHECKSUM_EN adds a 16-bit byte checksum output and
// a two-byte checksum trailer (low, high) after the last region byte.
module x1_ioctl_upload
  import x1_pkg::*;
#(
  parameter int          RD_LATENCY = 1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic [1:0]  mem_sel,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_q,
`ifdef X1_UPLOAD_CHECKSUM_EN
  output logic [15:0] checksum,
`endif
  output logic        done
);

  state_t      state_reg, state_next;
  logic [16:0] ptr_reg, ptr_next;
  logic [16:0] size_reg, size_next;
  logic        up_prev_reg;
  logic [7:0]  din_reg, din_next;
  logic        wait_reg, wait_next;
  logic [1:0]  sel_reg, sel_next;
  logic [15:0] addr_reg, addr_next;
  logic        rd_reg, rd_next;
  logic        done_reg, done_next;
  logic        lat_hit;
`ifdef X1_UPLOAD_CHECKSUM_EN
  logic [15:0] cks_reg, cks_next;
  logic [1:0]  trl_reg, trl_next;
`endif

  x1_upload_lat #(.RD_LATENCY(RD_LATENCY)) u_lat (
    .clk   (clk_sys),
    .srst  (reset),
    .flush (~ioctl_upload),
    .start (rd_reg),
    .hit   (lat_hit)
  );

  // State and output registers; the previous-upload flag resets high so a
  // session held open across reset needs a fresh rising edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      size_reg    <= '0;
      up_prev_reg <= 1'b1;
      din_reg     <= 8'h00;
      wait_reg    <= 1'b0;
      sel_reg     <= 2'd0;
      addr_reg    <= 16'd0;
      rd_reg      <= 1'b0;
      done_reg    <= 1'b0;
`ifdef X1_UPLOAD_CHECKSUM_EN
      cks_reg     <= 16'd0;
      trl_reg     <= 2'd0;
`endif
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      size_reg    <= size_next;
      up_prev_reg <= ioctl_upload;
      din_reg     <= din_next;
      wait_reg    <= wait_next;
      sel_reg     <= sel_next;
      addr_reg    <= addr_next;
      rd_reg      <= rd_next;
      done_reg    <= done_next;
`ifdef X1_UPLOAD_CHECKSUM_EN
      cks_reg     <= cks_next;
      trl_reg     <= trl_next;
`endif
    end
  end

  // Next-state logic: session start, per-byte fetch, latency wait and handoff.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    size_next  = size_reg;
    din_next   = din_reg;
    wait_next  = wait_reg;
    sel_next   = sel_reg;
    addr_next  = addr_reg;
    rd_next    = 1'b0;
    done_next  = 1'b0;
`ifdef X1_UPLOAD_CHECKSUM_EN
    cks_next   = cks_reg;
    trl_next   = trl_reg;
`endif
    if (!ioctl_upload) begin
      // Session closed by the HPS: abandon any fetch, keep the last byte.
      state_next = ST_IDLE;
      wait_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!up_prev_reg) begin
            sel_next   = ioctl_index[1:0];
            size_next  = region_size(ioctl_index);
            ptr_next   = '0;
            wait_next  = 1'b1;
            state_next = ST_FETCH;
`ifdef X1_UPLOAD_CHECKSUM_EN
            cks_next   = 16'd0;
            trl_next   = 2'd0;
`endif
          end
        end
        ST_FETCH: begin
          if (ptr_reg < size_reg) begin
            rd_next    = 1'b1;
            addr_next  = ptr_reg[15:0];
            state_next = ST_WAITQ;
          end else begin
            din_next   = FILL_BYTE;
`ifdef X1_UPLOAD_CHECKSUM_EN
            // Checksum trailer replaces the first two fill bytes of a real region.
            if (size_reg != 17'd0 && trl_reg == 2'd0) begin
              din_next = cks_reg[7:0];
              trl_next = 2'd1;
            end else if (size_reg != 17'd0 && trl_reg == 2'd1) begin
              din_next = cks_reg[15:8];
              trl_next = 2'd2;
            end
`endif
            wait_next  = 1'b0;
            state_next = ST_VALID;
          end
        end
        ST_WAITQ: begin
          if (lat_hit) begin
            din_next   = mem_q;
            wait_next  = 1'b0;
            state_next = ST_VALID;
`ifdef X1_UPLOAD_CHECKSUM_EN
            cks_next   = cks_reg + {8'd0, mem_q};
`endif
          end
        end
        ST_VALID: begin
          if (ioctl_rd) begin
            if (ptr_reg != PTR_MAX) ptr_next = ptr_reg + 17'd1;
            if (ptr_reg + 17'd1 == size_reg) done_next = 1'b1;
            wait_next  = 1'b1;
            state_next = ST_FETCH;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Hook for the HPS byte address: it must track the internal pointer.
  addr_tracks_ptr: assert property (@(posedge clk_sys) disable iff (reset)
    (state_reg == ST_VALID && ioctl_upload && ioctl_rd) |-> (ioctl_addr == {8'd0, ptr_reg}));

  assign ioctl_din  = din_reg;
  assign ioctl_wait = wait_reg;
  assign mem_sel    = sel_reg;
  assign mem_addr   = addr_reg;
  assign mem_rd     = rd_reg;
  assign done       = done_reg;
`ifdef X1_UPLOAD_CHECKSUM_EN
  assign checksum   = cks_reg;
`endif

endmodule

// File: tb/tb_x1_ioctl_upload.sv
// Bench for x1_ioctl_upload: a behavioural session model checked every
// cycle, a latency-accurate port-B memory, and literal per-test expectations.
module tb_x1_ioctl_upload;

  localparam int LAT = 3;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [1:0]  mem_sel;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic        done;
`ifdef X1_UPLOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk_sys = ~clk_sys;

  x1_ioctl_upload #(.RD_LATENCY(LAT), .FILL_BYTE(8'hFF)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_q        (mem_q),
`ifdef X1_UPLOAD_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .done         (done)
  );

  // Region contents and a port-B read pipe with LAT cycles of latency.
  logic [7:0] mem [0:3][0:65535];
  logic [7:0] pipe [0:LAT-1];
  always @(posedge clk_sys) begin
    if (mem_rd) pipe[0] <= mem[mem_sel][mem_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rsize(input int idx);
    case (idx)
      0:       return 8192;
      1, 2:    return 65536;
      3:       return 4096;
      default: return 0;
    endcase
  endfunction

  // ---------------- behavioural session model ----------------
  bit         m_active, m_prev, m_wait, m_done, m_memrd, m_inreg;
  int         m_idx, m_ptr, m_cnt, m_fills;
  logic [7:0] m_din;
  logic [15:0] m_sum;

  function automatic logic [7:0] exp_byte();
    if (m_ptr < rsize(m_idx)) return mem[m_idx][m_ptr];
`ifdef X1_UPLOAD_CHECKSUM_EN
    if (rsize(m_idx) != 0 && m_fills == 0) return m_sum[7:0];
    if (rsize(m_idx) != 0 && m_fills == 1) return m_sum[15:8];
`endif
    return 8'hFF;
  endfunction

  task automatic sched();
    m_wait  = 1'b1;
    m_inreg = (m_ptr < rsize(m_idx));
    m_cnt   = m_inreg ? 2 + LAT : 1;
  endtask

  always @(posedge clk_sys) begin
    if (reset) begin
      m_active = 0; m_prev = 1; m_wait = 0; m_din = 8'h00;
      m_done = 0; m_memrd = 0; m_cnt = 0;
    end else begin
      m_done = 0; m_memrd = 0;
      if (!ioctl_upload) begin
        m_active = 0; m_wait = 0; m_cnt = 0;
      end else if (!m_active) begin
        if (!m_prev) begin
          m_active = 1; m_idx = int'(ioctl_index); m_ptr = 0; m_sum = 0; m_fills = 0;
          sched();
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_inreg && m_cnt == LAT + 1) m_memrd = 1;
        if (m_cnt == 0) begin
          m_din  = exp_byte();
          m_wait = 0;
          if (m_inreg) m_sum = m_sum + 16'(m_din);
          else         m_fills++;
        end
      end else if (ioctl_rd) begin
        if (m_ptr + 1 == rsize(m_idx)) m_done = 1;
        if (m_ptr < 65536) m_ptr++;
        sched();
      end
      m_prev = ioctl_upload;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("wait", 32'(ioctl_wait), 32'(m_wait));
      chk("done", 32'(done), 32'(m_done));
      chk("mem_rd", 32'(mem_rd), 32'(m_memrd));
      if (m_memrd) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_ptr[15:0]));
        chk("mem_sel", 32'(mem_sel), 32'(m_idx[1:0]));
      end
      if (!m_wait) chk("din", 32'(ioctl_din), 32'(m_din));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic start_session(input logic [7:0] idx);
    ioctl_index  = idx;
    ioctl_upload = 1'b1;
    cyc(1);
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_rd(input int len);
    ioctl_addr = 25'(m_ptr);
    ioctl_rd   = 1'b1;
    cyc(len);
    ioctl_rd   = 1'b0;
  endtask

  task automatic get_byte(output logic [7:0] b, input int exp_lat);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 50) begin
      cyc(1);
      n++;
    end
    if (n >= 50) chk("valid_timeout", 32'(n), 32'(exp_lat));
    chk("latency", 32'(n), 32'(exp_lat));
    b = ioctl_din;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] e;
    int len;
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0; ioctl_addr = '0;
    for (int r = 0; r < 4; r++)
      for (int a = 0; a < 65536; a++)
        mem[r][a] = (r == 0) ? 8'(a) : 8'($urandom);
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_wait", 32'(ioctl_wait), 32'h0);
    chk("rst_mem_rd", 32'(mem_rd), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_sel", 32'(mem_sel), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    cyc(2);

    // IPL: full region, done on the 8192nd read, then out-of-range bytes.
    start_session(8'd0);
    for (int i = 0; i < 8195; i++) begin
      get_byte(b, (i < 8192) ? 2 + LAT : 1);
      if (i < 8192) e = 8'(i);
`ifdef X1_UPLOAD_CHECKSUM_EN
      else if (i == 8192) e = 8'h00;
      else if (i == 8193) e = 8'hF0;
`endif
      else e = 8'hFF;
      chk("ipl_byte", 32'(b), 32'(e));
      pulse_rd(1);
      chk("ipl_done", 32'(done), 32'(i == 8191));
    end
    end_session();

    // RAM: random gaps and injected reads while ioctl_wait is high.
    start_session(8'd1);
    len = 1;
    for (int i = 0; i < 40; i++) begin
      get_byte(b, 2 + LAT - (len - 1));
      chk("ram_byte", 32'(b), 32'(mem[1][i]));
      cyc($urandom_range(0, 2));
      len = ($urandom_range(0, 3) == 0) ? 2 : 1;
      if (len == 2) $display("note: protocol error injected, ioctl_rd during ioctl_wait after byte %0d", i);
      pulse_rd(len);
    end
    get_byte(b, 2 + LAT - (len - 1));
    chk("ram_byte_last", 32'(b), 32'(mem[1][40]));
    end_session();

    // Invalid index: fill only, no reads, no done.
    start_session(8'd7);
    for (int i = 0; i < 6; i++) begin
      get_byte(b, 1);
      chk("inv_byte", 32'(b), 32'hFF);
      pulse_rd(1);
      chk("inv_done", 32'(done), 32'h0);
    end
    end_session();

    // VRAM: abort after byte 100, restart from address 0.
    start_session(8'd3);
    for (int i = 0; i < 100; i++) begin
      get_byte(b, 2 + LAT);
      chk("vram_byte", 32'(b), 32'(mem[3][i]));
      pulse_rd(1);
    end
    cyc($urandom_range(0, 3));
    end_session();
    start_session(8'd3);
    get_byte(b, 2 + LAT);
    chk("vram_restart0", 32'(b), 32'(mem[3][0]));
    pulse_rd(1);
    get_byte(b, 2 + LAT);
    chk("vram_restart1", 32'(b), 32'(mem[3][1]));
    end_session();

    // GRAM: rising edge coincides with ioctl_rd, then reset mid-session.
    ioctl_rd = 1'b1;
    start_session(8'd2);
    ioctl_rd = 1'b0;
    get_byte(b, 2 + LAT);
    chk("gram_edge_rd0", 32'(b), 32'(mem[2][0]));
    pulse_rd(1);
    get_byte(b, 2 + LAT);
    chk("gram_edge_rd1", 32'(b), 32'(mem[2][1]));
    reset = 1'b1;
    cyc(1);
    chk("mid_rst_din", 32'(ioctl_din), 32'h00);
    chk("mid_rst_wait", 32'(ioctl_wait), 32'h0);
    chk("mid_rst_mem_sel", 32'(mem_sel), 32'h0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    reset = 1'b0;
    cyc(6);
    chk("no_auto_restart", 32'(ioctl_wait), 32'h0);
    end_session();
    start_session(8'd2);
    get_byte(b, 2 + LAT);
    chk("gram_after_rst", 32'(b), 32'(mem[2][0]));
    end_session();

`ifdef X1_UPLOAD_CHECKSUM_EN
    // Checksum: VRAM of all 01 sums to 1000, trailer 00 then 10.
    for (int a = 0; a < 4096; a++) mem[3][a] = 8'h01;
    start_session(8'd3);
    for (int i = 0; i < 4096; i++) begin
      get_byte(b, 2 + LAT);
      chk("cks_vram_byte", 32'(b), 32'h01);
      pulse_rd(1);
    end
    chk("cks_done", 32'(done), 32'h1);
    chk("cks_value", 32'(checksum), 32'h1000);
    get_byte(b, 1);
    chk("cks_trailer_lo", 32'(b), 32'h00);
    pulse_rd(1);
    get_byte(b, 1);
    chk("cks_trailer_hi", 32'(b), 32'h10);
    pulse_rd(1);
    get_byte(b, 1);
    chk("cks_fill", 32'(b), 32'hFF);
    end_session();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
